// File: rtl/vga_sync_decoder.sv
`timescale 1ns/1ps
// Sink-side VGA timing decoder: measures line/frame totals from active-low syncs sampled on
// pix_en ticks, recovers the active pixel coordinate and reports lock / loss of lock.
module vga_sync_decoder #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int H_PW         = 96,
    parameter int H_BP         = 48,
    parameter int V_PW         = 2,
    parameter int V_BP         = 29,
    parameter int COUNTER_BITS = 10,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic                    clk_50MHz,
    input  logic                    clear,
    input  logic                    pix_en,
    input  logic                    h_sync,
    input  logic                    v_sync,
    output logic [COUNTER_BITS-1:0] x,
    output logic [COUNTER_BITS-1:0] y,
    output logic                    pixel_valid,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    locked,
    output logic                    sync_error,
    output logic [COUNTER_BITS-1:0] h_total,
    output logic [COUNTER_BITS-1:0] v_total
);

    localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_BITS-1:0] H_FIRST = COUNTER_BITS'(H_PW + H_BP);
    localparam logic [COUNTER_BITS-1:0] H_END   = COUNTER_BITS'(H_PW + H_BP + H_RES);
    localparam logic [COUNTER_BITS-1:0] V_FIRST = COUNTER_BITS'(V_PW + V_BP);
    localparam logic [COUNTER_BITS-1:0] V_END   = COUNTER_BITS'(V_PW + V_BP + V_RES);
    localparam logic [2:0]              LOCK_MAX = 3'(LOCK_FRAMES);

    logic                    h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic [COUNTER_BITS-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [COUNTER_BITS-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [COUNTER_BITS-1:0] x_q, x_d, y_q, y_d;
    logic                    h_valid_q, h_valid_d, v_valid_q, v_valid_d;
    logic                    v_seen_q, v_seen_d, line_bad_q, line_bad_d;
    logic                    v_pending_q, v_pending_d;
    logic [2:0]              lock_cnt_q, lock_cnt_d;
    logic                    locked_q, locked_d, pixel_valid_q, pixel_valid_d;
    logic                    line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic                    sync_error_q, sync_error_d;

    logic                    hfall, vfall, hc_sat, vc_sat, active_h, active_v;
    logic [COUNTER_BITS-1:0] h_meas, v_meas;

    assign hfall  = h_sync_q & ~h_sync;
    assign vfall  = v_sync_q & ~v_sync;
    assign hc_sat = (hc_q == CNT_MAX);
    assign vc_sat = (vc_q == CNT_MAX);
    assign h_meas = hc_sat ? CNT_MAX : hc_q + 1'b1;
    assign v_meas = vc_sat ? CNT_MAX : vc_q + 1'b1;

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_valid = pixel_valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_error  = sync_error_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;

    always_comb begin
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        hc_d          = hc_q;
        vc_d          = vc_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        x_d           = x_q;
        y_d           = y_q;
        h_valid_d     = h_valid_q;
        v_valid_d     = v_valid_q;
        v_seen_d      = v_seen_q;
        line_bad_d    = line_bad_q;
        v_pending_d   = v_pending_q;
        lock_cnt_d    = lock_cnt_q;
        locked_d      = locked_q;
        pixel_valid_d = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        sync_error_d  = 1'b0;
        active_h      = 1'b0;
        active_v      = 1'b0;

        if (pix_en) begin
            h_sync_d = h_sync;
            v_sync_d = v_sync;

            // Frame end is handled before the line edge so a coincident hfall starts the new frame.
            if (vfall) begin
                v_pending_d   = 1'b1;
                frame_start_d = 1'b1;
                line_bad_d    = 1'b0;
                if (!v_seen_q) begin
                    v_seen_d = 1'b1;
                end else if (!v_valid_q) begin
                    v_total_d = v_meas;
                    v_valid_d = 1'b1;
                end else begin
                    if (v_meas == v_total_q && !line_bad_q && !hc_sat && !vc_sat) begin
                        lock_cnt_d = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 3'd1;
                    end else begin
                        lock_cnt_d   = 3'd0;
                        sync_error_d = 1'b1;
                    end
                    v_total_d = v_meas;
                end
            end

            if (hfall) begin
                if (h_valid_q && h_meas != h_total_q) begin
                    line_bad_d = 1'b1;
                end
                h_total_d    = h_meas;
                h_valid_d    = !hc_sat;
                line_start_d = 1'b1;
                hc_d         = '0;
                if (v_pending_d) begin
                    vc_d        = '0;
                    v_pending_d = 1'b0;
                end else begin
                    vc_d = v_meas;
                end
            end else begin
                hc_d = h_meas;
            end

            // Losing h_sync long enough to saturate the line counter forces full re-qualification.
            if (hc_d == CNT_MAX && !hc_sat) begin
                lock_cnt_d   = 3'd0;
                sync_error_d = 1'b1;
                h_valid_d    = 1'b0;
                v_valid_d    = 1'b0;
            end

            active_h = (hc_d >= H_FIRST) && (hc_d < H_END);
            active_v = (vc_d >= V_FIRST) && (vc_d < V_END);
            if (active_h) begin
                x_d = hc_d - H_FIRST;
            end
            if (active_v) begin
                y_d = vc_d - V_FIRST;
            end
            locked_d      = (lock_cnt_d == LOCK_MAX);
            pixel_valid_d = active_h && active_v && locked_d;
        end
    end

    always_ff @(posedge clk_50MHz or posedge clear) begin
        if (clear) begin
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            hc_q          <= CNT_MAX;
            vc_q          <= CNT_MAX;
            h_total_q     <= '0;
            v_total_q     <= '0;
            x_q           <= '0;
            y_q           <= '0;
            h_valid_q     <= 1'b0;
            v_valid_q     <= 1'b0;
            v_seen_q      <= 1'b0;
            line_bad_q    <= 1'b0;
            v_pending_q   <= 1'b0;
            lock_cnt_q    <= 3'd0;
            locked_q      <= 1'b0;
            pixel_valid_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_valid_q     <= h_valid_d;
            v_valid_q     <= v_valid_d;
            v_seen_q      <= v_seen_d;
            line_bad_q    <= line_bad_d;
            v_pending_q   <= v_pending_d;
            lock_cnt_q    <= lock_cnt_d;
            locked_q      <= locked_d;
            pixel_valid_q <= pixel_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            sync_error_q  <= sync_error_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
// Bench for vga_sync_decoder: drives a scaled-down VGA timing stream and scoreboards
// every tick's registered outputs against expectations derived from the stream position.
module tb_vga_sync_decoder;

    localparam int HP = 4, HB = 4, HR = 16, HF = 4;
    localparam int VP = 2, VB = 3, VR = 5, VF = 2;
    localparam int HT = HP + HB + HR + HF;
    localparam int VT = VP + VB + VR + VF;
    localparam int HS = HP + HB;
    localparam int VS = VP + VB;
    localparam int CB = 10;

    typedef struct packed {
        logic [CB-1:0] x;
        logic [CB-1:0] y;
        logic          pv;
        logic          ls;
        logic          fs;
        logic          lk;
        logic          se;
    } exp_t;

    logic          clk_50MHz = 1'b0;
    logic          clear = 1'b1;
    logic          pix_en = 1'b0;
    logic          h_sync = 1'b1;
    logic          v_sync = 1'b1;
    logic [CB-1:0] x, y, h_total, v_total;
    logic          pixel_valid, line_start, frame_start, locked, sync_error;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic          tick_s, clr_s;
    logic [CB-1:0] mdl_x = '0, mdl_y = '0;
    int            n_checks = 0, n_pass = 0;
    int            mon_se_cnt = 0, mon_both_cnt = 0, frame_pv_cnt = 0;
    logic [CB-1:0] first_pv_x = '0, first_pv_y = '0, last_pv_x = '0, last_pv_y = '0;

    vga_sync_decoder #(
        .H_RES(HR), .V_RES(VR), .H_PW(HP), .H_BP(HB), .V_PW(VP), .V_BP(VB),
        .COUNTER_BITS(CB), .LOCK_FRAMES(2)
    ) dut (
        .clk_50MHz(clk_50MHz), .clear(clear), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
        .x(x), .y(y), .pixel_valid(pixel_valid), .line_start(line_start),
        .frame_start(frame_start), .locked(locked), .sync_error(sync_error),
        .h_total(h_total), .v_total(v_total)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Scoreboard consumer: each tick's expectation is popped one cycle after it was driven.
    always @(posedge clk_50MHz) begin
        tick_s = pix_en;
        clr_s  = clear;
        #1;
        if (!clr_s && !clear) begin
            if (tick_s) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL scoreboard_empty: output tick with no expectation queued");
                end else begin
                    n_pass++;
                    mon_e = exp_q.pop_front();
                    n_checks++;
                    if (x !== mon_e.x) $display("[TB] FAIL x: got %0d expected %0d", x, mon_e.x);
                    else n_pass++;
                    n_checks++;
                    if (y !== mon_e.y) $display("[TB] FAIL y: got %0d expected %0d", y, mon_e.y);
                    else n_pass++;
                    n_checks++;
                    if (pixel_valid !== mon_e.pv) $display("[TB] FAIL pixel_valid: got %b expected %b (x=%0d y=%0d)", pixel_valid, mon_e.pv, mon_e.x, mon_e.y);
                    else n_pass++;
                    n_checks++;
                    if (line_start !== mon_e.ls) $display("[TB] FAIL line_start: got %b expected %b", line_start, mon_e.ls);
                    else n_pass++;
                    n_checks++;
                    if (frame_start !== mon_e.fs) $display("[TB] FAIL frame_start: got %b expected %b", frame_start, mon_e.fs);
                    else n_pass++;
                    n_checks++;
                    if (locked !== mon_e.lk) $display("[TB] FAIL locked: got %b expected %b", locked, mon_e.lk);
                    else n_pass++;
                    n_checks++;
                    if (sync_error !== mon_e.se) $display("[TB] FAIL sync_error: got %b expected %b", sync_error, mon_e.se);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if ({pixel_valid, line_start, frame_start, sync_error} !== 4'b0000)
                    $display("[TB] FAIL idle_pulses: got %b expected 0000", {pixel_valid, line_start, frame_start, sync_error});
                else n_pass++;
            end
            if (sync_error === 1'b1) mon_se_cnt++;
            if (line_start === 1'b1 && frame_start === 1'b1) mon_both_cnt++;
            if (frame_start === 1'b1) frame_pv_cnt = 0;
            if (pixel_valid === 1'b1) begin
                if (frame_pv_cnt == 0) begin
                    first_pv_x = x;
                    first_pv_y = y;
                end
                last_pv_x = x;
                last_pv_y = y;
                frame_pv_cnt++;
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_tick(input logic h, input logic v, input exp_t e);
        @(negedge clk_50MHz);
        pix_en = 1'b1;
        h_sync = h;
        v_sync = v;
        exp_q.push_back(e);
        @(negedge clk_50MHz);
        pix_en = 1'b0;
    endtask

    // Lines [0,n_lines) of one frame; the frame starts with coincident h and v falling edges.
    task automatic send_frame(input bit exp_err, input bit exp_lk, input int short_line, input int n_lines);
        exp_t e;
        int   len;
        bit   ah, av;
        for (int ln = 0; ln < n_lines; ln++) begin
            len = (ln == short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                ah = (c >= HS) && (c < HS + HR);
                av = (ln >= VS) && (ln < VS + VR);
                if (ah) mdl_x = CB'(c - HS);
                if (av) mdl_y = CB'(ln - VS);
                e.x  = mdl_x;
                e.y  = mdl_y;
                e.pv = ah && av && exp_lk;
                e.ls = (c == 0);
                e.fs = (c == 0) && (ln == 0);
                e.se = exp_err && (c == 0) && (ln == 0);
                e.lk = exp_lk;
                drive_tick(c >= HP, ln >= VP, e);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk_50MHz);
        clear  = 1'b1;
        pix_en = 1'b0;
        h_sync = 1'b1;
        v_sync = 1'b1;
        #1;
        n_checks++;
        if ({x, y, h_total, v_total} !== '0) $display("[TB] FAIL reset_values: got x=%0d y=%0d h_total=%0d v_total=%0d expected all 0", x, y, h_total, v_total);
        else n_pass++;
        n_checks++;
        if ({pixel_valid, line_start, frame_start, locked, sync_error} !== 5'b0) $display("[TB] FAIL reset_flags: got %b expected 00000", {pixel_valid, line_start, frame_start, locked, sync_error});
        else n_pass++;
        exp_q.delete();
        mdl_x = '0;
        mdl_y = '0;
        repeat (3) @(negedge clk_50MHz);
        clear = 1'b0;
    endtask

    task automatic test_lock_acquire;
        int se0;
        se0 = mon_se_cnt;
        send_frame(0, 0, -1, VT);
        n_checks++;
        if (h_total !== CB'(HT)) $display("[TB] FAIL acq_h_total: got %0d expected %0d", h_total, HT);
        else n_pass++;
        n_checks++;
        if (v_total !== '0) $display("[TB] FAIL acq_v_total_partial: got %0d expected 0", v_total);
        else n_pass++;
        send_frame(0, 0, -1, VT);
        n_checks++;
        if (v_total !== CB'(VT)) $display("[TB] FAIL acq_v_total: got %0d expected %0d", v_total, VT);
        else n_pass++;
        send_frame(0, 0, -1, VT);
        send_frame(0, 1, -1, VT);
        n_checks++;
        if (locked !== 1'b1) $display("[TB] FAIL acq_locked: got %b expected 1", locked);
        else n_pass++;
        n_checks++;
        if (mon_se_cnt - se0 != 0) $display("[TB] FAIL acq_no_error: got %0d errors expected 0", mon_se_cnt - se0);
        else n_pass++;
    endtask

    task automatic test_pixels;
        send_frame(0, 1, -1, VT);
        n_checks++;
        if (frame_pv_cnt != HR * VR) $display("[TB] FAIL pix_count: got %0d expected %0d", frame_pv_cnt, HR * VR);
        else n_pass++;
        n_checks++;
        if (first_pv_x !== '0 || first_pv_y !== '0) $display("[TB] FAIL pix_first: got (%0d,%0d) expected (0,0)", first_pv_x, first_pv_y);
        else n_pass++;
        n_checks++;
        if (last_pv_x !== CB'(HR - 1) || last_pv_y !== CB'(VR - 1)) $display("[TB] FAIL pix_last: got (%0d,%0d) expected (%0d,%0d)", last_pv_x, last_pv_y, HR - 1, VR - 1);
        else n_pass++;
    endtask

    task automatic test_short_line;
        int se0;
        se0 = mon_se_cnt;
        send_frame(0, 1, 3, VT);
        send_frame(1, 0, -1, VT);
        n_checks++;
        if (mon_se_cnt - se0 != 1) $display("[TB] FAIL short_error_count: got %0d expected 1", mon_se_cnt - se0);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("[TB] FAIL short_unlocked: got %b expected 0", locked);
        else n_pass++;
        send_frame(0, 0, -1, VT);
        send_frame(0, 1, -1, VT);
        n_checks++;
        if (locked !== 1'b1 || v_total !== CB'(VT)) $display("[TB] FAIL short_relock: got locked=%b v_total=%0d expected 1/%0d", locked, v_total, VT);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int   se0, k_sat;
        exp_t e;
        se0   = mon_se_cnt;
        k_sat = (2 ** CB - 1) - HT;
        send_frame(0, 1, -1, 7);
        for (int k = 0; k < 1100; k++) begin
            e.x  = mdl_x;
            e.y  = mdl_y;
            e.pv = 1'b0;
            e.ls = 1'b0;
            e.fs = 1'b0;
            e.se = (k == k_sat);
            e.lk = (k < k_sat);
            drive_tick(1'b1, 1'b1, e);
        end
        n_checks++;
        if (mon_se_cnt - se0 != 1) $display("[TB] FAIL timeout_error_count: got %0d expected 1", mon_se_cnt - se0);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b0 || h_total !== CB'(HT)) $display("[TB] FAIL timeout_state: got locked=%b h_total=%0d expected 0/%0d", locked, h_total, HT);
        else n_pass++;
        send_frame(0, 0, -1, VT);
        n_checks++;
        if (v_total !== CB'(7)) $display("[TB] FAIL timeout_requalify: got v_total=%0d expected 7", v_total);
        else n_pass++;
        send_frame(1, 0, -1, VT);
        send_frame(0, 0, -1, VT);
        send_frame(0, 1, -1, VT);
        n_checks++;
        if (locked !== 1'b1 || h_total !== CB'(HT) || v_total !== CB'(VT)) $display("[TB] FAIL timeout_relock: got locked=%b h=%0d v=%0d expected 1/%0d/%0d", locked, h_total, v_total, HT, VT);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        int se0, both0;
        se0   = mon_se_cnt;
        both0 = mon_both_cnt;
        send_frame(0, 1, -1, VT);
        send_frame(0, 1, -1, VT);
        n_checks++;
        if (mon_both_cnt - both0 != 2) $display("[TB] FAIL simul_pulses: got %0d expected 2", mon_both_cnt - both0);
        else n_pass++;
        n_checks++;
        if (h_total !== CB'(HT) || v_total !== CB'(VT) || mon_se_cnt != se0) $display("[TB] FAIL simul_totals: got h=%0d v=%0d errors=%0d expected %0d/%0d/0", h_total, v_total, mon_se_cnt - se0, HT, VT);
        else n_pass++;
    endtask

    task automatic test_clear_midframe;
        int se0;
        send_frame(0, 1, -1, 4);
        test_reset();
        se0 = mon_se_cnt;
        send_frame(0, 0, -1, VT);
        send_frame(0, 0, -1, VT);
        send_frame(0, 0, -1, VT);
        n_checks++;
        if (locked !== 1'b0) $display("[TB] FAIL clear_early_lock: got %b expected 0", locked);
        else n_pass++;
        send_frame(0, 1, -1, VT);
        n_checks++;
        if (locked !== 1'b1 || mon_se_cnt != se0) $display("[TB] FAIL clear_relock: got locked=%b errors=%0d expected 1/0", locked, mon_se_cnt - se0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_pixels();
        test_short_line();
        test_timeout();
        test_simultaneous();
        test_clear_midframe();
        repeat (4) @(negedge clk_50MHz);
        n_checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Sink-side counterpart to the VGA timing generator. Samples incoming h_sync, v_sync (active-low pulses) on 25 MHz pixel-enable ticks inside the 50 MHz domain.
- Measures line and frame totals, recovers the active pixel coordinate (x, y) and flags lock and loss of lock.
- Used by capture and self-check logic that sits downstream of a VGA-style timing source.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
H_PW, 96, h_sync pulse width in ticks
H_BP, 48, horizontal back porch in ticks
V_PW, 2, v_sync pulse width in lines
V_BP, 29, vertical back porch in lines
COUNTER_BITS, 10, width of all counters and coordinate outputs
LOCK_FRAMES, 2, consecutive consistent frames required for lock (1..7)

Ports:
clk_50MHz  in  1  system clock
clear  in  1  asynchronous active-high reset
pix_en  in  1  one-cycle tick per pixel (every 2nd clk_50MHz); all sampling is qualified by it
h_sync  in  1  horizontal sync, active low
v_sync  in  1  vertical sync, active low
x  out  COUNTER_BITS  active pixel column
y  out  COUNTER_BITS  active pixel row
pixel_valid  out  1  one-cycle pulse: x,y address an active pixel, and locked=1
line_start  out  1  one-cycle pulse on each detected h_sync falling edge
frame_start  out  1  one-cycle pulse on each detected v_sync falling edge
locked  out  1  timing stable
sync_error  out  1  one-cycle pulse on a timing mismatch or timeout
h_total  out  COUNTER_BITS  last measured line length in ticks
v_total  out  COUNTER_BITS  last measured frame length in lines

Behaviour:
- Reset:
  - x, y, h_total, v_total, lock_cnt = 0; all pulses 0; locked = 0.
  - hc, vc = all ones (saturated); h_sync_q, v_sync_q = 1, so no spurious edge is seen after reset.
  - Flags h_valid, v_valid, v_seen, line_bad, v_pending = 0.
- All state updates occur only on cycles with pix_en=1. Every output is registered and reflects the tick sampled in the previous cycle (latency 1 clk_50MHz). Pulse outputs are 0 on all non-tick-follow cycles.
- Edge detect: hfall = h_sync_q & ~h_sync; vfall = v_sync_q & ~v_sync. The _q registers update every tick.
- hc: counts ticks since the last hfall.
  - hfall: hc <= 0.
  - Otherwise hc <= hc+1, saturating at 2^COUNTER_BITS-1.
- On hfall:
  - If h_valid and (hc+1) != h_total: line_bad <= 1.
  - h_total <= hc+1 (saturating).
  - h_valid <= 1 only if hc was not saturated.
  - line_start pulses.
- vc: counts h_sync falling edges since frame start.
  - On hfall with v_pending=1: vc <= 0 and v_pending <= 0.
  - On hfall with v_pending=0: vc <= vc+1, saturating.
- On vfall:
  - v_pending <= 1; frame_start pulses.
  - Measured lines = vc+1 (saturating).
  - If v_seen=0: v_seen <= 1 only; the frame is partial and nothing is compared.
  - Else if v_valid=0: v_total <= measured; v_valid <= 1.
  - Else a frame is consistent when measured == v_total, line_bad=0, and neither hc nor vc saturated.
    - Consistent: lock_cnt <= min(lock_cnt+1, LOCK_FRAMES).
    - Not consistent: lock_cnt <= 0 and sync_error pulses.
    - Either way, v_total <= measured.
  - line_bad <= 0 in all vfall cases.
- Simultaneous hfall and vfall on the same tick: the vfall is processed first, so this hfall consumes v_pending and vc <= 0.
- locked = (lock_cnt == LOCK_FRAMES). With stable input, locked rises after the (LOCK_FRAMES+2)-th vfall following reset.
- Timeout: when hc reaches saturation:
  - lock_cnt <= 0, locked falls, sync_error pulses once on entry to saturation.
  - h_valid <= 0 and v_valid <= 0, so measurement must re-qualify from scratch.
- Coordinates, computed each tick:
  - active_h = hc in [H_PW+H_BP, H_PW+H_BP+H_RES); x = hc-(H_PW+H_BP).
  - active_v = vc in [V_PW+V_BP, V_PW+V_BP+V_RES); y = vc-(V_PW+V_BP).
  - pixel_valid = active_h & active_v & locked.
  - x, y hold their last values when not active.
- Reset mid-frame: all state returns to reset values immediately. Lock must be fully re-acquired, and no sync_error is raised from the partial frame.

Test Plan:
- Reset, then standard 800×525 timing, pix_en every other clock -> h_total=800; v_total=525 after 2nd vfall; locked rises at 4th vfall; no sync_error.
- Locked stream; first active tick (144 ticks after hfall, 31 lines after v_pending consumed) -> x=0, y=0, pixel_valid=1. Last active pixel -> x=639, y=479. 307200 pixel_valid pulses per frame.
- Locked; one line shortened to 799 ticks -> at next vfall sync_error pulses once, locked=0; relocks at 2nd following vfall with good timing.
- Locked; h_sync held high for 1100 ticks -> hc saturates at 1023, sync_error single pulse, locked=0, h_valid/v_valid cleared; after restoring timing, locked returns at 4th vfall.
- hfall and vfall on the same tick -> vc=0 on that tick, frame_start and line_start both pulse, totals unchanged for stable timing.
- Assert clear mid-frame while locked -> all outputs 0 next cycle; release -> no sync_error from the partial frame; locked at 4th vfall.
